// File: rtl/lcd_st7735_seq.sv
// ============================================================================
// Module      : lcd_st7735_seq
// Description : ST7735 power-up/init sequencer with run-time rectangle fill,
//               feeding a byte-level SPI writer through an en_write/wr_done handshake.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_st7735_seq #(
  parameter int unsigned T_RST_LOW  = 1_000_000,
  parameter int unsigned T_RST_HIGH = 1_000_000,
  parameter int unsigned T_SLPOUT   = 250_000,
  parameter int unsigned WIDTH      = 162,
  parameter int unsigned HEIGHT     = 132,
  parameter int unsigned X_OFS      = 0,
  parameter int unsigned Y_OFS      = 0,
  parameter logic [7:0]  MADCTL     = 8'h60,
  parameter int unsigned PIX_BITS   = 16,
  parameter logic [15:0] BG_COLOR   = 16'hAF7D
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        wr_done,
  output logic        en_write,
  output logic [8:0]  lcd_data,
  output logic        lcd_rst,
  input  logic        fill_valid,
  output logic        fill_ready,
  input  logic [7:0]  fill_x0,
  input  logic [7:0]  fill_x1,
  input  logic [7:0]  fill_y0,
  input  logic [7:0]  fill_y1,
  input  logic [15:0] fill_color,
  output logic        fill_err,
  output logic        busy,
  output logic        init_done
);

  typedef enum logic [2:0] {
    S_RST_LOW, S_RST_HIGH, S_SLPOUT, S_SLP_WAIT, S_INIT, S_WIN, S_PIX, S_IDLE
  } state_e;

  localparam logic [7:0]  COLMOD   = (PIX_BITS == 18) ? 8'h06 : 8'h05;
  localparam logic [1:0]  LAST_SUB = (PIX_BITS == 18) ? 2'd2 : 2'd1;
  localparam logic [7:0]  XO       = 8'(X_OFS);
  localparam logic [7:0]  YO       = 8'(Y_OFS);
  localparam logic [31:0] INIT_LAST = 32'd76;

  localparam logic [8:0] INIT_TBL [0:76] = '{
    9'h0B1, 9'h101, 9'h12C, 9'h12D,  9'h0B2, 9'h101, 9'h12C, 9'h12D,
    9'h0B3, 9'h101, 9'h12C, 9'h12D, 9'h101, 9'h12C, 9'h12D,  9'h0B4, 9'h107,
    9'h0C0, 9'h1A2, 9'h102, 9'h184,  9'h0C1, 9'h1C5,  9'h0C2, 9'h10A, 9'h100,
    9'h0C3, 9'h18A, 9'h12A,  9'h0C4, 9'h18A, 9'h1EE,  9'h0C5, 9'h10E,
    9'h036, {1'b1, MADCTL},
    9'h0E0, 9'h102, 9'h11C, 9'h107, 9'h112, 9'h137, 9'h132, 9'h129, 9'h12D,
            9'h129, 9'h125, 9'h12B, 9'h139, 9'h100, 9'h101, 9'h103, 9'h110,
    9'h0E1, 9'h103, 9'h11D, 9'h107, 9'h106, 9'h12E, 9'h12C, 9'h129, 9'h12D,
            9'h12E, 9'h12E, 9'h137, 9'h13F, 9'h100, 9'h100, 9'h102, 9'h110,
    9'h0F0, 9'h101,  9'h0F6, 9'h100,  9'h03A, {1'b1, COLMOD},  9'h029
  };

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  sub_q, sub_d;
  logic [15:0] pix_q, pix_d;
  logic        en_q, en_d;
  logic [8:0]  data_q, data_d;
  logic        lcd_rst_q, lcd_rst_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [15:0] color_q, color_d;

  logic [8:0]  tx_byte;
  logic        sending;
  logic        byte_done;
  logic [8:0]  span_x, span_y;
  logic [17:0] area;

  always_comb begin
    span_x = {1'b0, x1_q} - {1'b0, x0_q} + 9'd1;
    span_y = {1'b0, y1_q} - {1'b0, y0_q} + 9'd1;
    area   = {9'd0, span_x} * {9'd0, span_y};
  end

  always_comb begin
    tx_byte = 9'h100;
    case (state_q)
      S_SLPOUT: tx_byte = 9'h011;
      S_INIT:   tx_byte = INIT_TBL[cnt_q[6:0]];
      S_WIN: begin
        case (cnt_q[3:0])
          4'd0:    tx_byte = 9'h02A;
          4'd2:    tx_byte = {1'b1, x0_q + XO};
          4'd4:    tx_byte = {1'b1, x1_q + XO};
          4'd5:    tx_byte = 9'h02B;
          4'd7:    tx_byte = {1'b1, y0_q + YO};
          4'd9:    tx_byte = {1'b1, y1_q + YO};
          4'd10:   tx_byte = 9'h02C;
          default: tx_byte = 9'h100;
        endcase
      end
      S_PIX: begin
        // 18-bit mode expands each RGB565 channel to 6 bits, MSB replicated into the LSB
        if (PIX_BITS == 18) begin
          case (sub_q)
            2'd0:    tx_byte = {1'b1, color_q[15:11], color_q[15], 2'b00};
            2'd1:    tx_byte = {1'b1, color_q[10:5], 2'b00};
            default: tx_byte = {1'b1, color_q[4:0], color_q[4], 2'b00};
          endcase
        end else begin
          tx_byte = (sub_q == 2'd0) ? {1'b1, color_q[15:8]} : {1'b1, color_q[7:0]};
        end
      end
      default: tx_byte = 9'h100;
    endcase
  end

  assign sending   = (state_q == S_SLPOUT) || (state_q == S_INIT) ||
                     (state_q == S_WIN)    || (state_q == S_PIX);
  assign byte_done = en_q && wr_done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    pix_d   = pix_q;
    en_d    = en_q;
    data_d  = data_q;
    err_d   = 1'b0;
    done_d  = done_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    color_d = color_q;

    // An idle handshake cycle loads the next byte; wr_done then retires it
    if (sending) begin
      if (!en_q) begin
        en_d   = 1'b1;
        data_d = tx_byte;
      end else if (wr_done) begin
        en_d = 1'b0;
      end
    end

    case (state_q)
      S_RST_LOW: begin
        if (cnt_q == T_RST_LOW - 1) begin
          state_d = S_RST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RST_HIGH: begin
        if (cnt_q == T_RST_HIGH - 1) begin
          state_d = S_SLPOUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_SLPOUT: begin
        if (byte_done) begin
          state_d = S_SLP_WAIT;
          cnt_d   = '0;
        end
      end
      S_SLP_WAIT: begin
        if (cnt_q == T_SLPOUT - 1) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_INIT: begin
        if (byte_done) begin
          if (cnt_q == INIT_LAST) begin
            state_d = S_WIN;
            cnt_d   = '0;
            x0_d    = 8'd0;
            x1_d    = 8'(WIDTH - 1);
            y0_d    = 8'd0;
            y1_d    = 8'(HEIGHT - 1);
            color_d = BG_COLOR;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_WIN: begin
        if (byte_done) begin
          if (cnt_q == 32'd10) begin
            state_d = S_PIX;
            cnt_d   = '0;
            sub_d   = 2'd0;
            pix_d   = area[15:0] - 16'd1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_PIX: begin
        if (byte_done) begin
          if (sub_q == LAST_SUB) begin
            sub_d = 2'd0;
            if (pix_q == 16'd0) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              pix_d = pix_q - 16'd1;
            end
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end
      end
      default: begin
        if (fill_valid && ready_q) begin
          x0_d    = fill_x0;
          x1_d    = fill_x1;
          y0_d    = fill_y0;
          y1_d    = fill_y1;
          color_d = fill_color;
          if ((fill_x1 < fill_x0) || (fill_y1 < fill_y0) ||
              ({1'b0, fill_x1} >= 9'(WIDTH)) || ({1'b0, fill_y1} >= 9'(HEIGHT))) begin
            err_d = 1'b1;
          end else begin
            state_d = S_WIN;
            cnt_d   = '0;
          end
        end
      end
    endcase

    lcd_rst_d = (state_d != S_RST_LOW);
    ready_d   = (state_d == S_IDLE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_RST_LOW;
      cnt_q     <= '0;
      sub_q     <= '0;
      pix_q     <= '0;
      en_q      <= 1'b0;
      data_q    <= 9'h100;
      lcd_rst_q <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      color_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
      pix_q     <= pix_d;
      en_q      <= en_d;
      data_q    <= data_d;
      lcd_rst_q <= lcd_rst_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      y0_q      <= y0_d;
      y1_q      <= y1_d;
      color_q   <= color_d;
    end
  end

  assign en_write   = en_q;
  assign lcd_data   = data_q;
  assign lcd_rst    = lcd_rst_q;
  assign fill_ready = ready_q;
  assign fill_err   = err_q;
  assign busy       = busy_q;
  assign init_done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_st7735_seq.sv
// ============================================================================
// Module      : tb_lcd_st7735_seq
// Description : Directed bench for lcd_st7735_seq: a 16-bit instance (A) and an
//               18-bit instance with RAM offsets (B), each with a writer model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lcd_st7735_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, wd_a, en_a, lcdrst_a, fv_a, fr_a, err_a, busy_a, done_a;
  logic [8:0] data_a;
  logic [7:0] x0_a, x1_a, y0_a, y1_a;
  logic [15:0] col_a;
  logic rst_b, wd_b, en_b, lcdrst_b, fv_b, fr_b, err_b, busy_b, done_b;
  logic [8:0] data_b;
  logic [7:0] x0_b, x1_b, y0_b, y1_b;
  logic [15:0] col_b;

  lcd_st7735_seq #(
    .T_RST_LOW(10), .T_RST_HIGH(10), .T_SLPOUT(5), .WIDTH(4), .HEIGHT(2),
    .X_OFS(0), .Y_OFS(0), .MADCTL(8'h60), .PIX_BITS(16), .BG_COLOR(16'hF800)
  ) dut_a (
    .sys_clk(clk), .sys_rst(rst_a), .wr_done(wd_a), .en_write(en_a), .lcd_data(data_a),
    .lcd_rst(lcdrst_a), .fill_valid(fv_a), .fill_ready(fr_a), .fill_x0(x0_a), .fill_x1(x1_a),
    .fill_y0(y0_a), .fill_y1(y1_a), .fill_color(col_a), .fill_err(err_a), .busy(busy_a),
    .init_done(done_a)
  );

  lcd_st7735_seq #(
    .T_RST_LOW(10), .T_RST_HIGH(10), .T_SLPOUT(5), .WIDTH(4), .HEIGHT(2),
    .X_OFS(2), .Y_OFS(1), .MADCTL(8'h60), .PIX_BITS(18), .BG_COLOR(16'hF800)
  ) dut_b (
    .sys_clk(clk), .sys_rst(rst_b), .wr_done(wd_b), .en_write(en_b), .lcd_data(data_b),
    .lcd_rst(lcdrst_b), .fill_valid(fv_b), .fill_ready(fr_b), .fill_x0(x0_b), .fill_x1(x1_b),
    .fill_y0(y0_b), .fill_y1(y1_b), .fill_color(col_b), .fill_err(err_b), .busy(busy_b),
    .init_done(done_b)
  );

  logic [8:0] got_a[$];
  logic [8:0] got_b[$];
  logic [8:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Writer A also pulses wr_done spuriously whenever en_write is low
  initial begin : writer_a
    int c;
    c = 0;
    wd_a = 1'b0;
    forever begin
      @(negedge clk);
      if (en_a && !wd_a) begin
        if (c == 2) begin
          got_a.push_back(data_a);
          wd_a = 1'b1;
          c = 0;
        end else begin
          c++;
        end
      end else begin
        wd_a = !wd_a && !en_a;
        c = 0;
      end
    end
  end

  initial begin : writer_b
    int c;
    c = 0;
    wd_b = 1'b0;
    forever begin
      @(negedge clk);
      if (en_b && !wd_b) begin
        if (c == 2) begin
          got_b.push_back(data_b);
          wd_b = 1'b1;
          c = 0;
        end else begin
          c++;
        end
      end else begin
        wd_b = 1'b0;
        c = 0;
      end
    end
  end

  task automatic push_init(input logic [7:0] colmod);
    logic [8:0] tbl [0:76];
    tbl = '{
      9'h0B1, 9'h101, 9'h12C, 9'h12D,  9'h0B2, 9'h101, 9'h12C, 9'h12D,
      9'h0B3, 9'h101, 9'h12C, 9'h12D, 9'h101, 9'h12C, 9'h12D,  9'h0B4, 9'h107,
      9'h0C0, 9'h1A2, 9'h102, 9'h184,  9'h0C1, 9'h1C5,  9'h0C2, 9'h10A, 9'h100,
      9'h0C3, 9'h18A, 9'h12A,  9'h0C4, 9'h18A, 9'h1EE,  9'h0C5, 9'h10E,  9'h036, 9'h160,
      9'h0E0, 9'h102, 9'h11C, 9'h107, 9'h112, 9'h137, 9'h132, 9'h129, 9'h12D,
              9'h129, 9'h125, 9'h12B, 9'h139, 9'h100, 9'h101, 9'h103, 9'h110,
      9'h0E1, 9'h103, 9'h11D, 9'h107, 9'h106, 9'h12E, 9'h12C, 9'h129, 9'h12D,
              9'h12E, 9'h12E, 9'h137, 9'h13F, 9'h100, 9'h100, 9'h102, 9'h110,
      9'h0F0, 9'h101,  9'h0F6, 9'h100,  9'h03A, 9'h100,  9'h029};
    tbl[75] = {1'b1, colmod};
    exp_q.push_back(9'h011);
    for (int i = 0; i < 77; i++) exp_q.push_back(tbl[i]);
  endtask

  // Window bytes with already-offset coordinates
  task automatic push_win(input logic [7:0] xa, input logic [7:0] xb,
                          input logic [7:0] ya, input logic [7:0] yb);
    exp_q.push_back(9'h02A); exp_q.push_back(9'h100); exp_q.push_back({1'b1, xa});
    exp_q.push_back(9'h100); exp_q.push_back({1'b1, xb});
    exp_q.push_back(9'h02B); exp_q.push_back(9'h100); exp_q.push_back({1'b1, ya});
    exp_q.push_back(9'h100); exp_q.push_back({1'b1, yb});
    exp_q.push_back(9'h02C);
  endtask

  task automatic compare_stream(input string tag, input logic [8:0] got[$]);
    int n;
    check_eq({tag, "_len"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s[%0d]", tag, i), {23'd0, got[i]}, {23'd0, exp_q[i]});
  endtask

  task automatic fill_a(input logic [7:0] xa, input logic [7:0] xb,
                        input logic [7:0] ya, input logic [7:0] yb, input logic [15:0] c);
    x0_a = xa; x1_a = xb; y0_a = ya; y1_a = yb; col_a = c; fv_a = 1'b1;
    @(negedge clk);
    fv_a = 1'b0;
  endtask

  task automatic reject_a(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                          input logic [7:0] ya, input logic [7:0] yb);
    fill_a(xa, xb, ya, yb, 16'h1111);
    check_eq({tag, "_err_pulse"}, err_a, 1'b1);
    @(negedge clk);
    check_eq({tag, "_after"}, {err_a, fr_a, en_a, busy_a}, 4'b0100);
  endtask

  task automatic rise_cycles_a(input string tag);
    int n;
    n = 0;
    while (!lcdrst_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, n, 10);
  endtask

  task automatic wait_done_a(input string tag);
    int k;
    k = 0;
    while (!done_a && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, done_a, 1'b1);
  endtask

  task automatic wait_idle_a(input string tag);
    int k;
    k = 0;
    while (busy_a && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, busy_a, 1'b0);
  endtask

  initial begin : main
    int k;
    int hi;
    rst_a = 1'b1; fv_a = 1'b0; x0_a = '0; x1_a = '0; y0_a = '0; y1_a = '0; col_a = '0;
    rst_b = 1'b1; fv_b = 1'b0; x0_b = '0; x1_b = '0; y0_b = '0; y1_b = '0; col_b = '0;
    repeat (3) @(negedge clk);

    // Reset state and power-up timing of instance A
    check_eq("reset_outputs", {en_a, data_a, lcdrst_a, fr_a, err_a, busy_a, done_a},
             {1'b0, 9'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    got_a.delete();
    rst_a = 1'b0;
    rise_cycles_a("lcd_rst_rise");
    wait_done_a("init_done_a");
    exp_q.delete();
    push_init(8'h05);
    push_win(8'h00, 8'h03, 8'h00, 8'h01);
    for (int i = 0; i < 8; i++) begin exp_q.push_back(9'h1F8); exp_q.push_back(9'h100); end
    compare_stream("init_a", got_a);
    check_eq("idle_flags_a", {busy_a, fr_a, en_a}, 3'b010);

    // Rejected requests
    got_a.delete();
    reject_a("rej_x1_lt_x0", 8'd5, 8'd4, 8'd0, 8'd0);
    reject_a("rej_x1_eq_w", 8'd0, 8'd4, 8'd0, 8'd0);
    reject_a("rej_y1_lt_y0", 8'd0, 8'd0, 8'd1, 8'd0);
    reject_a("rej_y1_eq_h", 8'd0, 8'd3, 8'd0, 8'd2);
    repeat (5) @(negedge clk);
    check_eq("rej_no_bytes", got_a.size(), 0);

    // Accepted 16-bit fill
    fill_a(8'd1, 8'd2, 8'd0, 8'd1, 16'h1234);
    check_eq("accept_flags_a", {fr_a, busy_a}, 2'b01);
    wait_idle_a("fill_a_idle");
    exp_q.delete();
    push_win(8'h01, 8'h02, 8'h00, 8'h01);
    for (int i = 0; i < 4; i++) begin exp_q.push_back(9'h112); exp_q.push_back(9'h134); end
    compare_stream("fill_a", got_a);

    // Reset mid-PIX with a request held through the restart
    got_a.delete();
    fill_a(8'd0, 8'd3, 8'd0, 8'd1, 16'h00FF);
    k = 0;
    while (got_a.size() < 15 && k < 2000) begin @(negedge clk); k++; end
    check_eq("reached_pix", got_a.size() >= 15, 1'b1);
    rst_a = 1'b1;
    x0_a = 8'd3; x1_a = 8'd3; y0_a = 8'd1; y1_a = 8'd1; col_a = 16'hABCD; fv_a = 1'b1;
    @(negedge clk);
    check_eq("midpix_reset", {en_a, lcdrst_a, done_a, busy_a, fr_a}, 5'b00010);
    @(negedge clk);
    got_a.delete();
    rst_a = 1'b0;
    rise_cycles_a("lcd_rst_rise_2");
    wait_done_a("init_done_a2");
    check_eq("first_idle_ready", fr_a, 1'b1);
    @(negedge clk);
    check_eq("held_req_accepted", {fr_a, busy_a}, 2'b01);
    fv_a = 1'b0;
    wait_idle_a("held_req_idle");
    exp_q.delete();
    push_init(8'h05);
    push_win(8'h00, 8'h03, 8'h00, 8'h01);
    for (int i = 0; i < 8; i++) begin exp_q.push_back(9'h1F8); exp_q.push_back(9'h100); end
    push_win(8'h03, 8'h03, 8'h01, 8'h01);
    exp_q.push_back(9'h1AB); exp_q.push_back(9'h1CD);
    compare_stream("restart_a", got_a);

    // Instance B: 18-bit pixels with RAM offsets
    got_b.delete();
    rst_b = 1'b0;
    k = 0;
    while (!done_b && k < 4000) begin @(negedge clk); k++; end
    check_eq("init_done_b", done_b, 1'b1);
    exp_q.delete();
    push_init(8'h06);
    push_win(8'h02, 8'h05, 8'h01, 8'h02);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(9'h1FC); exp_q.push_back(9'h100); exp_q.push_back(9'h100);
    end
    compare_stream("init_b", got_b);

    got_b.delete();
    x0_b = 8'd1; x1_b = 8'd2; y0_b = 8'd1; y1_b = 8'd1; col_b = 16'h07E0; fv_b = 1'b1;
    @(negedge clk);
    fv_b = 1'b0;
    k = 0;
    hi = 0;
    while (busy_b && k < 2000) begin
      if (fr_b) hi++;
      @(negedge clk);
      k++;
    end
    check_eq("fill_b_ready_low", hi, 0);
    check_eq("fill_b_idle", {busy_b, fr_b}, 2'b01);
    exp_q.delete();
    push_win(8'h03, 8'h04, 8'h02, 8'h02);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(9'h100); exp_q.push_back(9'h1FC); exp_q.push_back(9'h100);
    end
    compare_stream("fill_b", got_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
